// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types and constants for the instruction fetch queue
package ifq_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    typedef enum logic [1:0] {IFQ_BOOT, IFQ_RUN, IFQ_DRAIN} ifq_state_t;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifq_entry_t;
endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: synchronous FIFO with flush, used for in-flight PCs and the decode queue
//   clk, reset       clock, synchronous active-high reset
//   flush            empties the FIFO next cycle
//   push, wdata      write strobe and data (accepted when not full or when popping)
//   pop, rdata       read strobe and head data
//   count            current occupancy, $clog2(DEPTH+1) bits
module ifq_fifo import ifq_pkg::*; #(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic do_push, do_pop;
    assign do_pop  = pop && count != '0;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign rdata   = mem[rd];
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (do_push) mem[wr] <= wdata;
            if (do_push) wr <= wr == AW'(DEPTH - 1) ? '0 : wr + 1'b1;
            if (do_pop) rd <= rd == AW'(DEPTH - 1) ? '0 : rd + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: drives the PC register, issues in-order fetches and buffers {pc, instr} for decode
//   clk, reset                     clock, synchronous active-high reset
//   pc_i                           current PC from the PC register
//   pc_load_o, pc_next_o           PC register load strobe and value
//   redirect_i, redirect_pc_i      single-cycle redirect and its target
//   mem_req_o, mem_addr_o          read request (held until mem_gnt_i) and address
//   mem_gnt_i                      request accepted
//   mem_rvalid_i, mem_rdata_i      in-order read response
//   dec_valid_o, dec_ready_i       decode handshake
//   dec_pc_o, dec_instr_o          head entry
//   IFQ_BYPASS_EN                  define to forward a response straight to decode when the queue is empty
module ifetch_queue import ifq_pkg::*; #(
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUT   = 2,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_load_o,
    output logic [XLEN-1:0] pc_next_o,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] dec_pc_o,
    output logic [XLEN-1:0] dec_instr_o
);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int QW = $clog2(DEPTH + 1);
    ifq_state_t state, state_n;
    logic [OW-1:0] drop_cnt, drop_n, f_count, outstanding;
    logic [QW-1:0] q_count;
    logic [XLEN-1:0] f_pc;
    ifq_entry_t q_head;
    logic issue, grant, live, byp, push, pop;
    // live reads sit in the PC FIFO, reads orphaned by a redirect are only counted
    assign outstanding = f_count + drop_cnt;
    assign issue = !reset && state == IFQ_RUN && !redirect_i && outstanding < OW'(MAX_OUT)
                   && 32'(outstanding) + 32'(q_count) < 32'(DEPTH);
    assign grant = issue && mem_gnt_i;
    assign live  = mem_rvalid_i && drop_cnt == '0 && !redirect_i;
`ifdef IFQ_BYPASS_EN
    assign byp = live && q_count == '0 && dec_ready_i;
`else
    assign byp = 1'b0;
`endif
    assign push = live && !byp;
    assign pop  = q_count != '0 && dec_ready_i && !redirect_i;
    assign mem_req_o   = issue;
    assign mem_addr_o  = issue ? pc_i : '0;
    assign pc_load_o   = !reset && (redirect_i || state == IFQ_BOOT || grant);
    assign pc_next_o   = !pc_load_o ? '0 : redirect_i ? redirect_pc_i
                         : state == IFQ_BOOT ? RESET_VEC : pc_i + PC_STEP;
    assign dec_valid_o = !reset && (q_count != '0 || byp);
    assign dec_pc_o    = !dec_valid_o ? '0 : byp ? f_pc : q_head.pc;
    assign dec_instr_o = !dec_valid_o ? '0 : byp ? mem_rdata_i : q_head.instr;
    always_comb begin
        drop_n  = redirect_i ? outstanding - OW'(mem_rvalid_i)
                : drop_cnt - OW'(mem_rvalid_i && drop_cnt != '0);
        state_n = redirect_i ? (drop_n != '0 ? IFQ_DRAIN : IFQ_RUN)
                : (state == IFQ_BOOT || (state == IFQ_DRAIN && drop_cnt == '0)) ? IFQ_RUN : state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IFQ_BOOT;
            drop_cnt <= '0;
        end else begin
            state    <= state_n;
            drop_cnt <= drop_n;
        end
    end
    ifq_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_inflight (
        .clk(clk), .reset(reset), .flush(redirect_i),
        .push(grant), .wdata(pc_i), .pop(live), .rdata(f_pc), .count(f_count)
    );
    ifq_fifo #(.WIDTH($bits(ifq_entry_t)), .DEPTH(DEPTH)) u_queue (
        .clk(clk), .reset(reset), .flush(redirect_i),
        .push(push), .wdata({f_pc, mem_rdata_i}), .pop(pop), .rdata(q_head), .count(q_count)
    );
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: randomized bench for ifetch_queue against a queue-based reference model
module tb_ifetch_queue;
    import ifq_pkg::*;
    localparam int DEPTH = 4;
    localparam int MAX_OUT = 2;
    localparam logic [31:0] RV = 32'h100;
    logic clk = 1'b0, reset = 1'b1;
    logic [31:0] pc_reg = '0;
    logic [31:0] pc_i, pc_next_o, redirect_pc_i = '0, mem_addr_o, mem_rdata_i = '0, dec_pc_o, dec_instr_o;
    logic pc_load_o, redirect_i = 1'b0, mem_req_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic dec_valid_o, dec_ready_i = 1'b0;
    always #5 clk = ~clk;
    ifetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_VEC(RV)) dut (
        .clk(clk), .reset(reset), .pc_i(pc_i), .pc_load_o(pc_load_o), .pc_next_o(pc_next_o),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .dec_pc_o(dec_pc_o), .dec_instr_o(dec_instr_o)
    );
    always @(posedge clk) if (pc_load_o) pc_reg <= pc_next_o;
    assign pc_i = pc_reg;
    int checks = 0, failures = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5a5a_c3c3;
    endfunction
    typedef struct { logic [31:0] a; int t; } rd_t;
    rd_t memq[$];
    int last_t = 0, cyc = 0;
    int p_gnt = 100, p_ready = 100, p_redir = 0, lat_max = 1;
    logic [31:0] targets [4] = '{32'h200, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h1000};
    logic [31:0] m_fetch;
    logic [31:0] m_inf[$];
    ifq_entry_t m_q[$];
    int m_drop = 0;
    bit m_boot = 1, m_drain = 0;
    task automatic tick(input bit rst_in, input bit frc);
        bit rv, rd, grant, byp, exp_req, exp_load, exp_dv;
        logic [31:0] tgt, exp_next, rpc;
        int drop0, tot, tt;
        ifq_entry_t head;
        @(posedge clk);
        #1;
        cyc++;
        reset = rst_in;
        rd = !rst_in && (frc || $urandom_range(99) < p_redir);
        tgt = targets[$urandom_range(3)];
        rv = !rst_in && memq.size() > 0 && memq[0].t <= cyc;
        redirect_i = rd;
        redirect_pc_i = tgt;
        mem_rvalid_i = rv;
        mem_rdata_i = rv ? imem(memq[0].a) : $urandom;
        dec_ready_i = $urandom_range(99) < p_ready;
        #1;
        mem_gnt_i = mem_req_o && ($urandom_range(99) < p_gnt);
        @(negedge clk);
        if (rst_in) begin
            check("rst_req", {31'b0, mem_req_o}, 0);
            check("rst_addr", mem_addr_o, 0);
            check("rst_load", {31'b0, pc_load_o}, 0);
            check("rst_next", pc_next_o, 0);
            check("rst_dv", {31'b0, dec_valid_o}, 0);
            check("rst_dpc", dec_pc_o, 0);
            check("rst_dinstr", dec_instr_o, 0);
            memq.delete();
            last_t = 0;
            m_inf.delete();
            m_q.delete();
            m_drop = 0;
            m_boot = 1;
            m_drain = 0;
            m_fetch = RV;
            return;
        end
        drop0 = m_drop;
        tot = m_inf.size() + m_drop;
        exp_req = !m_boot && !m_drain && !rd && tot < MAX_OUT && tot + m_q.size() < DEPTH;
        grant = exp_req && mem_gnt_i;
        byp = 0;
`ifdef IFQ_BYPASS_EN
        byp = rv && drop0 == 0 && m_q.size() == 0 && m_inf.size() > 0 && dec_ready_i && !rd;
`endif
        exp_dv = m_q.size() > 0 || byp;
        head = '0;
        if (byp) head = '{pc: m_inf[0], instr: imem(m_inf[0])};
        else if (m_q.size() > 0) head = m_q[0];
        exp_load = m_boot || rd || grant;
        exp_next = rd ? tgt : m_boot ? RV : m_fetch + 32'd4;
        check("mem_req", {31'b0, mem_req_o}, {31'b0, exp_req});
        if (exp_req) check("mem_addr", mem_addr_o, m_fetch);
        check("pc_load", {31'b0, pc_load_o}, {31'b0, exp_load});
        if (exp_load) check("pc_next", pc_next_o, exp_next);
        check("dec_valid", {31'b0, dec_valid_o}, {31'b0, exp_dv});
        if (exp_dv) begin
            check("dec_pc", dec_pc_o, head.pc);
            check("dec_instr", dec_instr_o, head.instr);
        end
        if (rv) void'(memq.pop_front());
        if (mem_gnt_i) begin
            tt = cyc + int'($urandom_range(lat_max, 1));
            if (tt < last_t) tt = last_t;
            last_t = tt;
            memq.push_back('{a: mem_addr_o, t: tt});
        end
        if (rd) begin
            m_q.delete();
            m_inf.delete();
            m_drop = tot - int'(rv);
            m_drain = m_drop > 0;
            m_fetch = tgt;
            m_boot = 0;
        end else begin
            if (exp_dv && dec_ready_i && !byp) void'(m_q.pop_front());
            if (rv) begin
                if (drop0 > 0) m_drop--;
                else if (m_inf.size() > 0) begin
                    rpc = m_inf.pop_front();
                    if (!byp) m_q.push_back('{pc: rpc, instr: imem(rpc)});
                end
            end
            if (grant) begin
                m_inf.push_back(m_fetch);
                m_fetch = m_fetch + 32'd4;
            end
            if (m_drain && drop0 == 0) m_drain = 0;
            m_boot = 0;
        end
    endtask
    initial begin
        repeat (3) tick(1, 0);
        repeat (30) tick(0, 0);
        p_ready = 0;
        repeat (20) tick(0, 0);
        p_ready = 100;
        repeat (10) tick(0, 0);
        p_gnt = 60; p_ready = 70; lat_max = 4; p_redir = 5;
        repeat (1500) tick(0, 0);
        for (int r = 0; r < 10; r++) begin
            p_redir = 3;
            repeat (100) tick(0, 0);
            p_redir = 0;
            for (int k = 0; k < 50 && m_inf.size() == 0; k++) tick(0, 0);
            tick(0, 1);
            repeat (r % 3) tick(0, 0);
            repeat (2) tick(1, 0);
        end
        p_gnt = 100; p_ready = 30; lat_max = 2; p_redir = 8;
        repeat (1000) tick(0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
